// File: rtl/uart_packet_arbiter.sv
// Packet-boundary round-robin arbiter that merges NumReq byte streams onto one UART TX stream.
// Latency: 1 idle cycle to arbitrate, then combinational pass-through. Backpressure: ready_i passes straight to the owner.
module uart_packet_arbiter #(
   parameter int Width    = 8,
   parameter int NumReq   = 2,
   parameter int MaxBeats = 1026
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [NumReq-1:0]        valid_i,
   output logic [NumReq-1:0]        ready_o,
   input  logic [NumReq*Width-1:0]  data_i,
   input  logic [NumReq-1:0]        last_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [Width-1:0]         data_o,
   output logic                     last_o,
   output logic [NumReq-1:0]        grant_o,
   output logic                     timeout_o
);

   localparam int BeatWidth = $clog2(MaxBeats + 1);
   localparam int PtrWidth  = (NumReq > 1) ? $clog2(NumReq) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_LOCKED
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   // One register serves as both the current owner and the round-robin pointer.
   logic [PtrWidth-1:0]   r_ptr;
   logic [PtrWidth-1:0]   w_ptr_nxt;
   logic [BeatWidth-1:0]  r_beats;
   logic [BeatWidth-1:0]  w_beats_nxt;
   logic                  r_timeout;
   logic                  w_timeout_nxt;

   logic                  w_found;
   logic [PtrWidth-1:0]   w_win;
   logic                  w_fire;

   always_comb begin
      w_found = 1'b0;
      w_win   = r_ptr;
      for (int i = 1; i <= NumReq; i++) begin
         if (!w_found && valid_i[(int'(r_ptr) + i) % NumReq]) begin
            w_found = 1'b1;
            w_win   = PtrWidth'((int'(r_ptr) + i) % NumReq);
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_ptr_nxt     = r_ptr;
      w_beats_nxt   = r_beats;
      w_timeout_nxt = r_timeout;
      valid_o       = 1'b0;
      data_o        = '0;
      last_o        = 1'b0;
      ready_o       = '0;
      grant_o       = '0;
      w_fire        = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_ptr_nxt   = w_win;
               w_state_nxt = ST_LOCKED;
            end
         end
         ST_LOCKED: begin
            valid_o        = valid_i[r_ptr];
            data_o         = data_i[r_ptr*Width +: Width];
            last_o         = last_i[r_ptr];
            ready_o[r_ptr] = ready_i;
            grant_o[r_ptr] = 1'b1;
            w_fire         = valid_i[r_ptr] && ready_i;
            if (w_fire) begin
               if (last_i[r_ptr]) begin
                  w_state_nxt = ST_IDLE;
                  w_beats_nxt = '0;
               end else if (r_beats == BeatWidth'(MaxBeats - 1)) begin
                  // Watchdog counts accepted beats only, so a stalled source never trips it.
                  w_state_nxt   = ST_IDLE;
                  w_beats_nxt   = '0;
                  w_timeout_nxt = 1'b1;
               end else if (r_beats != BeatWidth'(MaxBeats)) begin
                  w_beats_nxt = r_beats + 1'b1;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_ptr     <= PtrWidth'(NumReq - 1);
         r_beats   <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ptr     <= w_ptr_nxt;
         r_beats   <= w_beats_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   assign timeout_o = r_timeout;

endmodule

// File: tb/tb_uart_packet_arbiter.sv
// Bench for uart_packet_arbiter: queue-based sources, a cycle reference model, directed then random traffic.
module tb_uart_packet_arbiter;

   localparam int W    = 8;
   localparam int N    = 2;
   localparam int MAXB = 8;

   logic          clk = 1'b0;
   logic          rst_i;
   logic [N-1:0]  valid_i;
   logic [N-1:0]  ready_o;
   logic [N*W-1:0] data_i;
   logic [N-1:0]  last_i;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  data_o;
   logic          last_o;
   logic [N-1:0]  grant_o;
   logic          timeout_o;

   uart_packet_arbiter #(.Width(W), .NumReq(N), .MaxBeats(MAXB)) dut (
      .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
      .last_i(last_i), .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o), .last_o(last_o),
      .grant_o(grant_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Source beat queues: {last, data}.
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [N-1:0] hold;

   // Reference model: packet-level ownership tracked with plain integers.
   bit m_locked;
   int m_owner;
   int m_ptr;
   int m_beats;
   bit m_timeout;

   logic [7:0] log_dat[$];
   logic [1:0] log_gnt[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pkt(input int src, input int len, input logic [7:0] base, input bit with_last);
      for (int i = 0; i < len; i++) begin
         logic [8:0] b;
         b = {(with_last && i == len - 1), 8'(base + 8'(i))};
         if (src == 0) q0.push_back(b); else q1.push_back(b);
      end
   endtask

   task automatic tick();
      bit          e_valid, e_last;
      logic [7:0]  e_data;
      logic [1:0]  e_ready, e_grant;
      valid_i[0] = (q0.size() > 0) && !hold[0];
      valid_i[1] = (q1.size() > 0) && !hold[1];
      data_i[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
      data_i[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
      last_i[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
      last_i[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
      @(negedge clk);
      e_valid = 1'b0; e_last = 1'b0; e_data = 8'h00; e_ready = 2'b00; e_grant = 2'b00;
      if (m_locked) begin
         e_valid = valid_i[m_owner];
         e_last  = last_i[m_owner];
         e_data  = data_i[m_owner*W +: W];
         e_ready = ready_i ? 2'(1 << m_owner) : 2'b00;
         e_grant = 2'(1 << m_owner);
      end
      chk("valid_o", 32'(valid_o), 32'(e_valid));
      chk("ready_o", 32'(ready_o), 32'(e_ready));
      chk("data_o", 32'(data_o), 32'(e_data));
      chk("last_o", 32'(last_o), 32'(e_last));
      chk("grant_o", 32'(grant_o), 32'(e_grant));
      chk("timeout_o", 32'(timeout_o), 32'(m_timeout));
      if (valid_o && ready_i) begin
         log_dat.push_back(data_o);
         log_gnt.push_back(grant_o);
      end
      @(posedge clk);
      if (e_ready[0] && valid_i[0]) void'(q0.pop_front());
      if (e_ready[1] && valid_i[1]) void'(q1.pop_front());
      if (rst_i) begin
         m_locked = 0; m_ptr = N - 1; m_beats = 0; m_timeout = 0;
      end else if (!m_locked) begin
         for (int i = 1; i <= N; i++) begin
            if (valid_i[(m_ptr + i) % N]) begin
               m_owner = (m_ptr + i) % N;
               m_ptr = m_owner;
               m_locked = 1;
               break;
            end
         end
      end else if (valid_i[m_owner] && ready_i) begin
         if (last_i[m_owner]) begin
            m_locked = 0; m_beats = 0;
         end else if (m_beats == MAXB - 1) begin
            m_locked = 0; m_beats = 0; m_timeout = 1;
         end else begin
            m_beats++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
   endtask

   // mode 0: ready always 1; 1: toggles 1,0,1,0...; 2: random.
   task automatic run_until_idle(input int mode, input string tag);
      int n;
      n = 0;
      if (mode == 1) ready_i = 1'b0;
      while ((q0.size() > 0 || q1.size() > 0 || m_locked) && n < 400) begin
         if (mode == 0) ready_i = 1'b1;
         else if (mode == 1) ready_i = ~ready_i;
         else ready_i = 1'($urandom_range(0, 1));
         tick();
         n++;
      end
      checks++;
      assert (n < 400) else begin
         failures++;
         $error("FAIL %s cycles=%0d required below 400", tag, n);
      end
      ready_i = 1'b1;
   endtask

   initial begin
      logic [7:0] exp1[4];
      int n;
      exp1 = '{8'h11, 8'h22, 8'h33, 8'hA5};
      hold = '0; rst_i = 1'b1; ready_i = 1'b1;
      valid_i = '0; data_i = '0; last_i = '0;
      m_locked = 0; m_owner = 0; m_ptr = N - 1; m_beats = 0; m_timeout = 0;
      #1;
      do_reset();
      tick();

      // Single source: 4 beats with last on the 4th.
      q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22});
      q0.push_back({1'b0, 8'h33}); q0.push_back({1'b1, 8'hA5});
      log_dat.delete(); log_gnt.delete();
      run_until_idle(0, "single_done");
      chk("single_nbeats", 32'(log_dat.size()), 32'd4);
      for (int i = 0; i < log_dat.size() && i < 4; i++) begin
         chk("single_data", 32'(log_dat[i]), 32'(exp1[i]));
         chk("single_gnt", 32'(log_gnt[i]), 32'd1);
      end

      // Contention: both sources request from reset, two 3-beat packets each.
      do_reset();
      push_pkt(0, 3, 8'h40, 1); push_pkt(0, 3, 8'h50, 1);
      push_pkt(1, 3, 8'h80, 1); push_pkt(1, 3, 8'h90, 1);
      log_dat.delete(); log_gnt.delete();
      run_until_idle(0, "contend_done");
      chk("contend_nbeats", 32'(log_gnt.size()), 32'd12);
      for (int i = 0; i < log_gnt.size() && i < 12; i++)
         chk("contend_order", 32'(log_gnt[i]), ((i / 3) % 2 == 1) ? 32'd2 : 32'd1);

      // Backpressure: 5-beat packet from src1 with ready toggling.
      push_pkt(1, 5, 8'hC0, 1);
      log_dat.delete(); log_gnt.delete();
      run_until_idle(1, "bp_done");
      chk("bp_fires", 32'(log_dat.size()), 32'd5);
      for (int i = 0; i < log_dat.size() && i < 5; i++)
         chk("bp_data", 32'(log_dat[i]), 32'(8'hC0 + 8'(i)));

      // Watchdog: src0 sends 10 beats (last only on the 10th), src1 waits with 3 beats.
      do_reset();
      push_pkt(0, 10, 8'h00, 1);
      push_pkt(1, 3, 8'hE0, 1);
      log_dat.delete(); log_gnt.delete();
      run_until_idle(0, "wd_done");
      chk("wd_timeout", 32'(timeout_o), 32'd1);
      chk("wd_nbeats", 32'(log_gnt.size()), 32'd13);
      for (int i = 0; i < log_gnt.size() && i < 13; i++)
         chk("wd_order", 32'(log_gnt[i]), (i >= 8 && i < 11) ? 32'd2 : 32'd1);

      // Mid-packet stall: src0 drops valid for 10 cycles after beat 2 while src1 waits.
      do_reset();
      push_pkt(0, 5, 8'h60, 1);
      push_pkt(1, 3, 8'h70, 1);
      log_dat.delete(); log_gnt.delete();
      n = 0;
      while (log_dat.size() < 2 && n < 50) begin tick(); n++; end
      hold[0] = 1'b1;
      repeat (10) tick();
      chk("stall_nbeats", 32'(log_dat.size()), 32'd2);
      chk("stall_gnt", 32'(grant_o), 32'd1);
      hold[0] = 1'b0;
      run_until_idle(0, "stall_done");
      chk("stall_total", 32'(log_gnt.size()), 32'd8);
      for (int i = 0; i < log_gnt.size() && i < 8; i++)
         chk("stall_order", 32'(log_gnt[i]), (i >= 5) ? 32'd2 : 32'd1);

      // Reset in the middle of a src1 packet.
      push_pkt(1, 5, 8'hB0, 1);
      log_dat.delete(); log_gnt.delete();
      n = 0;
      while (log_dat.size() < 2 && n < 50) begin tick(); n++; end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      q1.delete();
      push_pkt(0, 2, 8'h10, 1);
      push_pkt(1, 2, 8'h20, 1);
      chk("rst_gnt", 32'(grant_o), 32'd0);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_timeout", 32'(timeout_o), 32'd0);
      log_dat.delete(); log_gnt.delete();
      run_until_idle(0, "rst_done");
      chk("rst_first", (log_gnt.size() > 0) ? 32'(log_gnt[0]) : 32'hFF, 32'd1);

      // Random traffic against the model.
      for (int c = 0; c < 2500; c++) begin
         if (q0.size() == 0 && $urandom_range(0, 3) == 0)
            push_pkt(0, int'($urandom_range(1, 12)), 8'($urandom), 1);
         if (q1.size() == 0 && $urandom_range(0, 3) == 0)
            push_pkt(1, int'($urandom_range(1, 12)), 8'($urandom), 1);
         ready_i = ($urandom_range(0, 3) != 0);
         hold[0] = ($urandom_range(0, 7) == 0);
         hold[1] = ($urandom_range(0, 7) == 0);
         rst_i   = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
